// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-compatible display-side responder for the RS/RW/E LCD bus
//
// Captures bus cycles on the falling edge of E (after synchronization), decodes
// instructions, holds a 128-byte DDRAM and the address counter, models busy
// timing and answers busy-flag/address and DDRAM data reads.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   E, RS, RW         LCD bus strobe/select/direction (asynchronous to clk)
//   data_in           bus byte driven by the LCD driver
//   data_out, data_oe read response and its bus-drive enable
//   busy, ac          busy flag and address counter
//   display_on        D bit of Display Control
//   char_valid        one-cycle pulse per DDRAM write, with char_addr/char_data
//   violation         one-cycle pulse on a protocol error

module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 4000,
    parameter int CLEAR_CYCLES = 164000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       E,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       char_valid,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    output logic       violation
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_CLEARING
    } state_t;

    state_t state, state_next;

    logic          e_s1, e_s2, e_s3;
    logic          rs_s1, rs_s2;
    logic          rw_s1, rw_s2;
    logic [7:0]    d_s1, d_s2;
    logic          e_rise, e_fall;

    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    clr_idx, clr_idx_next;   // bit 7 set once all 128 cells are cleared
    logic          id, id_next;             // I/D: 1 = increment
    logic          cgram, cgram_next;       // CGRAM addressing mode
    logic [6:0]    ac_next, ac_step;
    logic          disp_next;
    logic          char_valid_next, violation_next;
    logic [6:0]    char_addr_next;
    logic [7:0]    char_data_next;
    logic          start_busy;

    logic          ddram_we;
    logic [6:0]    ddram_waddr;
    logic [7:0]    ddram_wdata;
    logic [7:0]    ddram [128];

    assign e_rise  = e_s2 & ~e_s3;
    assign e_fall  = ~e_s2 & e_s3;
    assign busy    = (state != ST_IDLE);
    assign data_oe = e_s2 & rw_s2;
    assign ac_step = id ? (ac + 7'd1) : (ac - 7'd1);

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        clr_idx_next    = clr_idx;
        id_next         = id;
        cgram_next      = cgram;
        ac_next         = ac;
        disp_next       = display_on;
        char_valid_next = 1'b0;
        violation_next  = 1'b0;
        char_addr_next  = char_addr;
        char_data_next  = char_data;
        start_busy      = 1'b0;
        ddram_we        = 1'b0;
        ddram_waddr     = clr_idx[6:0];
        ddram_wdata     = 8'h20;

        case (state)
            ST_BUSY: begin
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            ST_CLEARING: begin
                // Fill proceeds one cell per cycle while the busy countdown runs.
                if (!clr_idx[7]) begin
                    ddram_we     = 1'b1;
                    clr_idx_next = clr_idx + 8'd1;
                end
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: ;
        endcase

        if (e_fall) begin
            if (rw_s2 && !rs_s2) begin
                // Status read: always legal, no state change.
            end else if (busy) begin
                violation_next = 1'b1;
            end else if (rw_s2) begin
                ac_next = ac_step;
            end else if (rs_s2) begin
                start_busy = 1'b1;
                if (!cgram) begin
                    ddram_we        = 1'b1;
                    ddram_waddr     = ac;
                    ddram_wdata     = d_s2;
                    char_valid_next = 1'b1;
                    char_addr_next  = ac;
                    char_data_next  = d_s2;
                    ac_next         = ac_step;
                end
            end else begin
                casez (d_s2)
                    8'b1???????: begin
                        ac_next    = d_s2[6:0];
                        cgram_next = 1'b0;
                        start_busy = 1'b1;
                    end
                    8'b01??????: begin
                        cgram_next = 1'b1;
                        start_busy = 1'b1;
                    end
                    8'b001?????: begin
                        // Only the 8-bit interface exists; asking for 4-bit is an error.
                        violation_next = ~d_s2[4];
                        start_busy     = 1'b1;
                    end
                    8'b0001????: begin
                        if (!d_s2[3]) ac_next = d_s2[2] ? (ac + 7'd1) : (ac - 7'd1);
                        start_busy = 1'b1;
                    end
                    8'b00001???: begin
                        disp_next  = d_s2[2];
                        start_busy = 1'b1;
                    end
                    8'b000001??: begin
                        id_next    = d_s2[1];
                        start_busy = 1'b1;
                    end
                    8'b0000001?: begin
                        ac_next    = 7'd0;
                        start_busy = 1'b1;
                    end
                    8'b00000001: begin
                        state_next   = ST_CLEARING;
                        cnt_next     = CW'(CLEAR_CYCLES - 1);
                        clr_idx_next = 8'd0;
                        ac_next      = 7'd0;
                        id_next      = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (start_busy) begin
                state_next = ST_BUSY;
                cnt_next   = CW'(BUSY_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_s1       <= 1'b0;
            e_s2       <= 1'b0;
            e_s3       <= 1'b0;
            rs_s1      <= 1'b0;
            rs_s2      <= 1'b0;
            rw_s1      <= 1'b0;
            rw_s2      <= 1'b0;
            d_s1       <= 8'd0;
            d_s2       <= 8'd0;
            state      <= ST_IDLE;
            cnt        <= '0;
            clr_idx    <= 8'd0;
            id         <= 1'b1;
            cgram      <= 1'b0;
            ac         <= 7'd0;
            display_on <= 1'b0;
            char_valid <= 1'b0;
            violation  <= 1'b0;
            char_addr  <= 7'd0;
            char_data  <= 8'd0;
            data_out   <= 8'd0;
        end else begin
            e_s1       <= E;
            e_s2       <= e_s1;
            e_s3       <= e_s2;
            rs_s1      <= RS;
            rs_s2      <= rs_s1;
            rw_s1      <= RW;
            rw_s2      <= rw_s1;
            d_s1       <= data_in;
            d_s2       <= d_s1;
            state      <= state_next;
            cnt        <= cnt_next;
            clr_idx    <= clr_idx_next;
            id         <= id_next;
            cgram      <= cgram_next;
            ac         <= ac_next;
            display_on <= disp_next;
            char_valid <= char_valid_next;
            violation  <= violation_next;
            char_addr  <= char_addr_next;
            char_data  <= char_data_next;
            // Read response is frozen at E rise so it is stable for the whole strobe.
            if (e_rise && rw_s2) data_out <= rs_s2 ? ddram[ac] : {busy, ac};
        end
    end

    // DDRAM has no reset: its content is undefined until the first Clear.
    always_ff @(posedge clk) begin
        if (ddram_we) ddram[ddram_waddr] <= ddram_wdata;
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - self-checking bench for lcd_bus_responder

module tb_lcd_bus_responder;

    localparam int BC = 8;
    localparam int CC = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       E = 1'b0, RS = 1'b0, RW = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       data_oe, busy, display_on, char_valid, violation;
    logic [6:0] ac, char_addr;
    logic [7:0] char_data;

    lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .reset_n(reset_n), .E(E), .RS(RS), .RW(RW), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .ac(ac),
        .display_on(display_on), .char_valid(char_valid), .char_addr(char_addr),
        .char_data(char_data), .violation(violation)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cv_cnt = 0, viol_cnt = 0, busy_cnt = 0;
    logic [6:0] cv_addr;
    logic [7:0] cv_data;

    // Reference model state
    logic [7:0] m_mem [128];
    int         m_ac = 0;
    bit         m_id = 1'b1;
    bit         m_disp = 1'b0;

    always @(negedge clk) begin
        if (char_valid) begin
            cv_cnt++;
            cv_addr = char_addr;
            cv_data = char_data;
        end
        if (violation) viol_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic int step(input int a);
        return m_id ? (a + 1) % 128 : (a + 127) % 128;
    endfunction

    task automatic clr_counts();
        cv_cnt = 0;
        viol_cnt = 0;
        busy_cnt = 0;
    endtask

    // One bus cycle, E high for 5 clocks; returns the read value and data_oe during/after E.
    task automatic bus(input bit rs, input bit rw, input logic [7:0] d,
                       output logic [7:0] rd, output logic oe_hi, output logic oe_lo);
        @(posedge clk); #1;
        RS = rs; RW = rw; data_in = d;
        repeat (2) @(posedge clk); #1;
        E = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rd = data_out;
        oe_hi = data_oe;
        @(posedge clk); #1;
        E = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        oe_lo = data_oe;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: busy still %0b after 1000 cycles, required 0", busy);
        end
    endtask

    task automatic wr_inst(input logic [7:0] d);
        logic [7:0] rd;
        logic oh, ol;
        bus(1'b0, 1'b0, d, rd, oh, ol);
        wait_idle();
    endtask

    task automatic wr_data(input logic [7:0] d);
        logic [7:0] rd;
        logic oh, ol;
        bus(1'b1, 1'b0, d, rd, oh, ol);
        wait_idle();
    endtask

    task automatic rd_data(output logic [7:0] rd);
        logic oh, ol;
        bus(1'b1, 1'b1, 8'h00, rd, oh, ol);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 7;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h need 00", data_out); end
        if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b need 0", data_oe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        if (ac !== 7'h00) begin errors++; $display("FAIL reset_ac: got %h need 00", ac); end
        if (display_on !== 1'b0) begin errors++; $display("FAIL reset_display_on: got %b need 0", display_on); end
        if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid: got %b need 0", char_valid); end
        if (violation !== 1'b0) begin errors++; $display("FAIL reset_violation: got %b need 0", violation); end
    endtask

    task automatic test_clear();
        logic [7:0] rd;
        clr_counts();
        wr_inst(8'h01);
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 0;
        m_id = 1'b1;
        checks += 3;
        if (busy_cnt != CC) begin errors++; $display("FAIL clear_busy_len: got %0d need %0d", busy_cnt, CC); end
        if (ac !== 7'h00) begin errors++; $display("FAIL clear_ac: got %h need 00", ac); end
        if (viol_cnt != 0) begin errors++; $display("FAIL clear_violation: got %0d need 0", viol_cnt); end
        for (int i = 0; i < 128; i++) begin
            rd_data(rd);
            checks++;
            if (rd !== m_mem[m_ac]) begin
                errors++;
                $display("FAIL clear_ddram[%0d]: got %h need %h", m_ac, rd, m_mem[m_ac]);
            end
            m_ac = step(m_ac);
        end
        checks++;
        if (ac !== 7'(m_ac)) begin errors++; $display("FAIL clear_read_wrap_ac: got %h need %h", ac, 7'(m_ac)); end
    endtask

    task automatic test_busy_violation();
        logic [7:0] rd;
        logic oh, ol;
        clr_counts();
        bus(1'b0, 1'b0, 8'h01, rd, oh, ol);
        bus(1'b0, 1'b0, 8'h0C, rd, oh, ol);
        bus(1'b0, 1'b1, 8'h00, rd, oh, ol);
        checks += 3;
        if (rd !== 8'h80) begin errors++; $display("FAIL busy_status_read: got %h need 80", rd); end
        if (oh !== 1'b1) begin errors++; $display("FAIL busy_oe_during_e: got %b need 1", oh); end
        if (ol !== 1'b0) begin errors++; $display("FAIL busy_oe_after_e: got %b need 0", ol); end
        bus(1'b1, 1'b0, 8'h55, rd, oh, ol);
        wait_idle();
        checks += 4;
        if (viol_cnt != 2) begin errors++; $display("FAIL busy_violations: got %0d need 2", viol_cnt); end
        if (busy_cnt != CC) begin errors++; $display("FAIL busy_not_restarted: got %0d need %0d", busy_cnt, CC); end
        if (cv_cnt != 0) begin errors++; $display("FAIL busy_write_ignored: got %0d char writes need 0", cv_cnt); end
        if (display_on !== 1'b0) begin errors++; $display("FAIL busy_inst_ignored: got display_on %b need 0", display_on); end
    endtask

    task automatic test_wrap();
        clr_counts();
        wr_inst(8'hFF);
        wr_data(8'h33);
        m_mem[127] = 8'h33;
        m_ac = 0;
        checks += 5;
        if (cv_cnt != 1) begin errors++; $display("FAIL wrap_char_count: got %0d need 1", cv_cnt); end
        if (cv_addr !== 7'h7F) begin errors++; $display("FAIL wrap_char_addr: got %h need 7f", cv_addr); end
        if (cv_data !== 8'h33) begin errors++; $display("FAIL wrap_char_data: got %h need 33", cv_data); end
        if (ac !== 7'h00) begin errors++; $display("FAIL wrap_ac: got %h need 00", ac); end
        if (busy_cnt != 2 * BC) begin errors++; $display("FAIL wrap_busy_len: got %0d need %0d", busy_cnt, 2 * BC); end
    endtask

    task automatic test_entry_dec();
        logic [7:0] rd;
        wr_inst(8'h04);
        m_id = 1'b0;
        wr_inst(8'h85);
        wr_data(8'h41);
        m_mem[5] = 8'h41;
        m_ac = 4;
        checks++;
        if (ac !== 7'h04) begin errors++; $display("FAIL entry_dec_ac: got %h need 04", ac); end
        wr_inst(8'h06);
        m_id = 1'b1;
        wr_inst(8'h85);
        rd_data(rd);
        m_ac = 6;
        checks += 2;
        if (rd !== m_mem[5]) begin errors++; $display("FAIL entry_dec_ddram5: got %h need %h", rd, m_mem[5]); end
        if (ac !== 7'h06) begin errors++; $display("FAIL entry_inc_ac: got %h need 06", ac); end
    endtask

    task automatic test_read_display();
        logic [7:0] rd;
        wr_inst(8'h90);
        wr_data(8'h5A);
        m_mem[16] = 8'h5A;
        wr_inst(8'h90);
        rd_data(rd);
        m_ac = 17;
        wr_inst(8'h0C);
        m_disp = 1'b1;
        checks += 3;
        if (rd !== 8'h5A) begin errors++; $display("FAIL read_data: got %h need 5a", rd); end
        if (ac !== 7'h11) begin errors++; $display("FAIL read_ac: got %h need 11", ac); end
        if (display_on !== 1'b1) begin errors++; $display("FAIL display_on: got %b need 1", display_on); end
    endtask

    task automatic test_cgram();
        logic [7:0] rd;
        clr_counts();
        wr_inst(8'h40);
        wr_data(8'hAA);
        checks += 2;
        if (cv_cnt != 0) begin errors++; $display("FAIL cgram_no_ddram_write: got %0d need 0", cv_cnt); end
        if (busy_cnt != 2 * BC) begin errors++; $display("FAIL cgram_busy_len: got %0d need %0d", busy_cnt, 2 * BC); end
        wr_inst(8'h80 | 8'(m_ac));
        rd_data(rd);
        checks++;
        if (rd !== m_mem[m_ac]) begin errors++; $display("FAIL cgram_ddram_kept: got %h need %h", rd, m_mem[m_ac]); end
        m_ac = step(m_ac);
    endtask

    task automatic test_random();
        logic [7:0] rd, b;
        logic oh, ol;
        int op, c0;
        clr_counts();
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: begin
                    m_ac = $urandom_range(0, 127);
                    wr_inst(8'h80 | 8'(m_ac));
                end
                1: begin
                    m_id = 1'($urandom_range(0, 1));
                    wr_inst(m_id ? 8'h06 : 8'h04);
                end
                2: begin
                    b = 8'($urandom);
                    c0 = cv_cnt;
                    wr_data(b);
                    checks += 3;
                    if (cv_cnt != c0 + 1) begin errors++; $display("FAIL rnd_char_count: got %0d need %0d", cv_cnt, c0 + 1); end
                    if (cv_addr !== 7'(m_ac)) begin errors++; $display("FAIL rnd_char_addr: got %h need %h", cv_addr, 7'(m_ac)); end
                    if (cv_data !== b) begin errors++; $display("FAIL rnd_char_data: got %h need %h", cv_data, b); end
                    m_mem[m_ac] = b;
                    m_ac = step(m_ac);
                end
                3: begin
                    rd_data(rd);
                    checks++;
                    if (rd !== m_mem[m_ac]) begin errors++; $display("FAIL rnd_read[%0d]: got %h need %h", m_ac, rd, m_mem[m_ac]); end
                    m_ac = step(m_ac);
                end
                4: begin
                    b = ($urandom_range(0, 1) != 0) ? 8'h14 : 8'h10;
                    wr_inst(b);
                    m_ac = b[2] ? (m_ac + 1) % 128 : (m_ac + 127) % 128;
                end
                5: begin
                    bus(1'b0, 1'b1, 8'h00, rd, oh, ol);
                    checks++;
                    if (rd !== {1'b0, 7'(m_ac)}) begin errors++; $display("FAIL rnd_status: got %h need %h", rd, {1'b0, 7'(m_ac)}); end
                end
                default: begin
                    m_disp = 1'($urandom_range(0, 1));
                    wr_inst(m_disp ? 8'h0C : 8'h08);
                end
            endcase
            checks += 2;
            if (ac !== 7'(m_ac)) begin errors++; $display("FAIL rnd_ac op%0d: got %h need %h", op, ac, 7'(m_ac)); end
            if (display_on !== m_disp) begin errors++; $display("FAIL rnd_display_on: got %b need %b", display_on, m_disp); end
        end
        checks++;
        if (viol_cnt != 0) begin errors++; $display("FAIL rnd_violations: got %0d need 0", viol_cnt); end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] rd;
        logic oh, ol;
        wr_inst(8'h97);
        bus(1'b0, 1'b0, 8'h01, rd, oh, ol);
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b need 0", busy); end
        if (ac !== 7'h00) begin errors++; $display("FAIL midreset_ac: got %h need 00", ac); end
        if (display_on !== 1'b0) begin errors++; $display("FAIL midreset_display_on: got %b need 0", display_on); end
        if (data_oe !== 1'b0) begin errors++; $display("FAIL midreset_data_oe: got %b need 0", data_oe); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_stays_idle: got busy %b need 0", busy); end
        clr_counts();
        wr_inst(8'h20);
        checks++;
        if (viol_cnt != 1) begin errors++; $display("FAIL funcset_4bit_violation: got %0d need 1", viol_cnt); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_clear();
        test_busy_violation();
        test_wrap();
        test_entry_dec();
        test_read_display();
        test_cgram();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
